// File: rtl/tft_spi_tx_if.sv
// tft_spi_tx_if: byte request handshake between the drawing stage and the SPI transmitter
interface tft_spi_tx_if;
    logic       tft_transmit;
    logic       tft_dc;
    logic [7:0] tft_data;
    logic       tft_busy;
    modport master (output tft_transmit, tft_dc, tft_data, input tft_busy);
    modport slave (input tft_transmit, tft_dc, tft_data, output tft_busy);
endinterface

// File: rtl/tft_spi_tx.sv
// tft_spi_tx: mode-0 SPI byte transmitter for a TFT panel with D/C line and chip-select hold
module tft_spi_tx #(
    parameter int CLK_DIV = 2,
    parameter int CS_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    tft_spi_tx_if.slave   tft,
    output logic          spi_sck,
    output logic          spi_mosi,
    output logic          spi_cs_n,
    output logic          spi_dc
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, HOLD} state_t;
    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] HOLD_LAST = 8'(CS_HOLD - 1);
    state_t     state, state_n;
    logic [7:0] div, div_n, idle_cnt, idle_n, shift, shift_n;
    logic [2:0] bits, bits_n;
    logic       dc_n, accept;
    assign accept   = tft.tft_transmit && !tft.tft_busy && (state == IDLE || state == HOLD);
    assign spi_mosi = shift[7];
    // next-state: a new byte always wins over the hold countdown
    always_comb begin
        state_n = state;
        div_n   = div;
        bits_n  = bits;
        idle_n  = idle_cnt;
        shift_n = shift;
        dc_n    = spi_dc;
        case (state)
            IDLE, HOLD: begin
                if (accept) begin
                    state_n = LOW;
                    div_n   = 8'd0;
                    bits_n  = 3'd0;
                    idle_n  = 8'd0;
                    shift_n = tft.tft_data;
                    dc_n    = tft.tft_dc;
                end else if (state == HOLD) begin
                    state_n = (idle_cnt == HOLD_LAST) ? IDLE : HOLD;
                    idle_n  = idle_cnt + 8'd1;
                end
            end
            LOW: begin
                state_n = (div == DIV_LAST) ? HIGH : LOW;
                div_n   = (div == DIV_LAST) ? 8'd0 : div + 8'd1;
            end
            HIGH: begin
                div_n = (div == DIV_LAST) ? 8'd0 : div + 8'd1;
                if (div == DIV_LAST) begin
                    if (bits == 3'd7) begin
                        state_n = (CS_HOLD == 0) ? IDLE : HOLD;
                        idle_n  = 8'd0;
                    end else begin
                        state_n = LOW;
                        bits_n  = bits + 3'd1;
                        shift_n = {shift[6:0], 1'b0};
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end
    // state, counters and registered pin drive derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            div          <= 8'd0;
            bits         <= 3'd0;
            idle_cnt     <= 8'd0;
            shift        <= 8'd0;
            spi_dc       <= 1'b0;
            tft.tft_busy <= 1'b0;
            spi_sck      <= 1'b0;
            spi_cs_n     <= 1'b1;
        end else begin
            state        <= state_n;
            div          <= div_n;
            bits         <= bits_n;
            idle_cnt     <= idle_n;
            shift        <= shift_n;
            spi_dc       <= dc_n;
            tft.tft_busy <= (state_n == LOW) || (state_n == HIGH);
            spi_sck      <= (state_n == HIGH);
            spi_cs_n     <= (state_n == IDLE);
        end
    end
endmodule

// File: tb/tb_tft_spi_tx.sv
// tb_tft_spi_tx: randomized byte traffic on two configurations checked against a per-byte timing model
module tb_tft_spi_tx;
    logic       clk = 1'b0;
    logic       rst, tr, dcin, sel;
    logic [7:0] din;
    int         n_checks = 0, n_fail = 0, since = 1000;
    logic       last_dc = 1'b0;
    logic       sck0, mosi0, csn0, dc0, sck1, mosi1, csn1, dc1;
    logic       busy, sck, mosi, cs_n, spi_dc;
    tft_spi_tx_if i0 ();
    tft_spi_tx_if i1 ();
    assign i0.tft_transmit = tr & ~sel;
    assign i0.tft_dc       = dcin;
    assign i0.tft_data     = din;
    assign i1.tft_transmit = tr & sel;
    assign i1.tft_dc       = dcin;
    assign i1.tft_data     = din;
    tft_spi_tx #(.CLK_DIV(2), .CS_HOLD(8)) dut0 (.clk(clk), .rst(rst), .tft(i0),
        .spi_sck(sck0), .spi_mosi(mosi0), .spi_cs_n(csn0), .spi_dc(dc0));
    tft_spi_tx #(.CLK_DIV(1), .CS_HOLD(0)) dut1 (.clk(clk), .rst(rst), .tft(i1),
        .spi_sck(sck1), .spi_mosi(mosi1), .spi_cs_n(csn1), .spi_dc(dc1));
    assign busy   = sel ? i1.tft_busy : i0.tft_busy;
    assign sck    = sel ? sck1 : sck0;
    assign mosi   = sel ? mosi1 : mosi0;
    assign cs_n   = sel ? csn1 : csn0;
    assign spi_dc = sel ? dc1 : dc0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one byte: pulse at T, then observe T+1 .. T+16*div+1
    task automatic send(input logic [7:0] d, input logic dc, input bit junk);
        int n = 16 * (sel ? 1 : 2);
        int rises = 0, bcount = 0, bad = 0;
        logic [7:0] got = 8'h00;
        logic ps = 1'b0, pm = 1'b0;
        tr = 1'b1; din = d; dcin = dc;
        tick();
        tr = 1'b0;
        check("start", {27'd0, busy, cs_n, spi_dc, mosi, sck}, {27'd0, 1'b1, 1'b0, dc, d[7], 1'b0});
        for (int c = 1; c <= n; c++) begin
            if (busy) bcount++;
            if (cs_n !== 1'b0 || spi_dc !== dc) bad++;
            if (c > 1 && mosi !== pm && !(ps && !sck)) bad++;
            if (sck && !ps) begin
                got = {got[6:0], mosi};
                rises++;
            end
            ps = sck;
            pm = mosi;
            if (junk && c == 5) begin
                tr = 1'b1; din = 8'hFF; dcin = ~dc;
            end else tr = 1'b0;
            tick();
        end
        tr = 1'b0;
        check("busy_fall", {31'd0, busy}, 32'd0);
        check("busy_len", bcount, n);
        check("sck_rises", rises, 8);
        check("byte", {24'd0, got}, {24'd0, d});
        check("in_byte", bad, 0);
        last_dc = dc;
        since = 0;
    endtask

    // observe g idle cycles plus the cycle in which the next request may be issued
    task automatic gap(input int g);
        int hold = sel ? 0 : 8;
        for (int k = 0; k <= g; k++) begin
            check("cs_hold", {31'd0, cs_n}, {31'd0, since >= hold});
            check("idle_pins", {29'd0, spi_dc, busy, sck}, {29'd0, last_dc, 2'b00});
            if (k < g) begin
                tick();
                since++;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        since = 1000;
        last_dc = 1'b0;
    endtask

    task automatic random_bytes(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            send(8'($urandom), 1'($urandom), $urandom_range(0, 3) == 0);
            gap($urandom_range(0, 12));
        end
    endtask

    initial begin
        int rises = 0, bad = 0;
        logic ps = 1'b0;
        rst = 1'b1; tr = 1'b0; sel = 1'b0; din = 8'h00; dcin = 1'b0;
        repeat (3) tick();
        check("rst0", {27'd0, i0.tft_busy, csn0, sck0, mosi0, dc0}, 32'b01000);
        check("rst1", {27'd0, i1.tft_busy, csn1, sck1, mosi1, dc1}, 32'b01000);
        rst = 1'b0;
        send(8'hA5, 1'b0, 1'b0);
        gap(12);
        send(8'h2A, 1'b0, 1'b0);
        gap(0);
        send(8'h00, 1'b1, 1'b0);
        gap(2);
        send(8'h05, 1'b1, 1'b0);
        gap(10);
        send(8'h3C, 1'b0, 1'b1);
        gap(10);
        random_bytes(20);
        tr = 1'b1; din = 8'h81; dcin = 1'b1;
        tick();
        tr = 1'b0;
        for (int c = 0; c < 40 && rises < 3; c++) begin
            if (sck && !ps) rises++;
            ps = sck;
            if (rises < 3) tick();
        end
        check("abort_rises", rises, 3);
        rst = 1'b1; tr = 1'b1; din = 8'hC3;
        tick();
        check("abort", {28'd0, busy, cs_n, sck, mosi}, 32'b0100);
        rst = 1'b0; tr = 1'b0;
        since = 1000; last_dc = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (busy || sck || !cs_n) bad++;
            tick();
        end
        check("post_abort", bad, 0);
        send(8'h7E, 1'b1, 1'b0);
        gap(10);
        send(8'h11, 1'b0, 1'b0);
        gap(7);
        send(8'h22, 1'b1, 1'b0);
        gap(9);
        sel = 1'b1;
        do_reset();
        send(8'h01, 1'b0, 1'b0);
        gap(0);
        send(8'h80, 1'b1, 1'b0);
        gap(3);
        random_bytes(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
